// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit sequencer state encoding.
package uart_pkg;

  localparam int TX_START_IDX     = 0;
  localparam int TX_STOP_IDX      = 9;
  localparam int TX_FRAME_BITS    = 10;
  localparam int DEFAULT_BAUD_DIV = 5208;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer-side request bundle: req/req_data in, one-cycle gnt back.
// Handshake: a requester raises req[i] with req_data lane i stable and holds
// both until it sees gnt[i]=1, then drops req[i] in that same cycle.
interface uart_tx_sched_if #(
  parameter int N_REQ = 2
) ();

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;

  modport master (output req, output req_data, input gnt);
  modport slave  (input req, input req_data, output gnt);

endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin select: first high req after rr_last, wrapping.
module uart_rr_arb #(
  parameter  int N_REQ = 2,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_last,
  output logic [N_REQ-1:0] sel,
  output logic [IW-1:0]    sel_idx,
  output logic             valid
);

  int idx;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    // Scan starts one past the last winner so the previous grantee goes last.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_last) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        sel[idx] = 1'b1;
        sel_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit sequencer: arbitrates byte requests, latches the byte and
// steps the bit index 0..9 at the baud rate for the serializer.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter  int N_REQ    = 2,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.slave   bus,
  output logic             busy,
  output logic             tx_sel_data,
  output logic [3:0]       tx_num,
  output logic [7:0]       tx_d,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_SEND = SEND;

  logic [0:0]       state;
  logic [CW-1:0]    baud_cnt;
  logic [IW-1:0]    rr_last;
  logic [N_REQ-1:0] sel;
  logic [IW-1:0]    sel_idx;
  logic             sel_valid;
  logic             baud_wrap;

  assign baud_wrap = (baud_cnt == CW'(BAUD_DIV - 1));
  assign dbg_state = state;

  uart_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req),
    .rr_last (rr_last),
    .sel     (sel),
    .sel_idx (sel_idx),
    .valid   (sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tx_sel_data <= 1'b0;
      tx_num      <= '0;
      tx_d        <= '0;
      bus.gnt     <= '0;
      busy        <= 1'b0;
      baud_cnt    <= '0;
      rr_last     <= IW'(N_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          bus.gnt <= '0;
          if (sel_valid) begin
            tx_d        <= bus.req_data[{sel_idx, 3'b000} +: 8];
            bus.gnt     <= sel;
            rr_last     <= sel_idx;
            tx_num      <= 4'(TX_START_IDX);
            baud_cnt    <= '0;
            tx_sel_data <= 1'b1;
            busy        <= 1'b1;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          bus.gnt <= '0;
          if (baud_wrap) begin
            baud_cnt <= '0;
            // Leaving on the stop-bit wrap lets IDLE re-arbitrate next cycle.
            if (tx_num == 4'(TX_STOP_IDX)) begin
              tx_sel_data <= 1'b0;
              busy        <= 1'b0;
              tx_num      <= '0;
              state       <= S_IDLE;
            end else begin
              tx_num <= tx_num + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a 2-requester instance checked by a grant/frame
// scoreboard, and a 1-requester instance checked for frame cadence.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int B1     = 4;
  localparam int N1     = 2;
  localparam int B2     = 2;
  localparam int N2     = 1;
  localparam int FRAME1 = TX_FRAME_BITS * B1;
  localparam int FRAME2 = TX_FRAME_BITS * B2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;

  uart_tx_sched_if #(.N_REQ(N1)) bus1 ();
  uart_tx_sched_if #(.N_REQ(N2)) bus2 ();

  logic       busy1, sel1, busy2, sel2;
  logic [3:0] num1, num2;
  logic [7:0] d1, d2;
  logic [0:0] st1, st2;

  uart_tx_sched #(.BAUD_DIV(B1), .N_REQ(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1),
    .tx_sel_data(sel1), .tx_num(num1), .tx_d(d1), .dbg_state(st1)
  );

  uart_tx_sched #(.BAUD_DIV(B2), .N_REQ(N2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave), .busy(busy2),
    .tx_sel_data(sel2), .tx_num(num2), .tx_d(d2), .dbg_state(st2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: {granted index, byte} in expected grant order
  logic [9:0] exp_q[$];
  int model_rr = N1 - 1;
  int g1_cnt   = 0;

  function automatic int rr_pick(input int last, input logic [N1-1:0] mask);
    for (int k = 1; k <= N1; k++) begin
      if (mask[(last + k) % N1]) return (last + k) % N1;
    end
    return -1;
  endfunction

  // monitor: pops on every grant, then checks the serial line for one frame
  initial begin
    bit         coll;
    int         k, bi, ferr, n;
    logic [7:0] fdat;
    logic [9:0] e;
    logic       expb, actb;
    coll = 0; k = 0; ferr = 0; fdat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        coll = 0;
      end else begin
        if (bus1.gnt != '0) begin
          g1_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", 32'(bus1.gnt), 0);
          end else begin
            e = exp_q.pop_front();
            check("gnt_sel", 32'(bus1.gnt), 32'(1) << e[9:8]);
            check("tx_d", 32'(d1), 32'(e[7:0]));
            fdat = e[7:0]; coll = 1; k = 0; ferr = 0;
          end
        end
        if (coll) begin
          if (k < FRAME1) begin
            bi   = k / B1;
            expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : fdat[bi-1];
            n    = int'(num1);
            actb = !sel1 ? 1'b1 : (n == 0) ? 1'b0 : (n >= 9) ? 1'b1 : d1[n-1];
            if (actb !== expb || busy1 !== 1'b1) ferr++;
            k++;
          end else begin
            check("frame_bits_err", ferr, 0);
            check("sel_drop", 32'(sel1), 0);
            check("busy_drop", 32'(busy1), 0);
            coll = 0;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 2 * FRAME1; c++) begin
      @(negedge clk);
      if (!busy1) begin ok = 1; break; end
    end
    check("idle_timeout", 32'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, 32'(bus1.gnt), 0);
    check({tag, "_busy"}, 32'(busy1), 0);
    check({tag, "_sel"}, 32'(sel1), 0);
    check({tag, "_num"}, 32'(num1), 0);
    check({tag, "_txd"}, 32'(d1), 0);
    check({tag, "_state"}, 32'(st1), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    exp_q.delete();
    model_rr = N1 - 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [1:0] mask, input logic [7:0] da,
                           input logic [7:0] db, input int count);
    int rr, got, cyc, i;
    rr = model_rr; got = 0; cyc = 0;
    for (int n = 0; n < count; n++) begin
      i = rr_pick(rr, mask);
      exp_q.push_back({2'(i), (i == 0) ? da : db});
      rr = i;
    end
    model_rr = rr;
    @(negedge clk);
    bus1.req_data = {db, da};
    bus1.req      = mask;
    while (got < count) begin
      @(negedge clk);
      cyc++;
      if (bus1.gnt != '0) begin
        if (got == 0) check("first_latency", cyc, 1);
        else          check("gnt_period", cyc, FRAME1 + 1);
        got++; cyc = 0;
        if (got == count) bus1.req = '0;
      end else if (cyc > FRAME1 + 10) begin
        check("gnt_timeout", 0, 1);
        bus1.req = '0;
        exp_q.delete();
        break;
      end
    end
    wait_idle();
  endtask

  task automatic midframe_reset();
    bit ok;
    int g0, bad;
    exp_q.push_back({2'(rr_pick(model_rr, 2'b01)), 8'h3C});
    model_rr = 0;
    @(negedge clk);
    bus1.req_data = {8'h00, 8'h3C};
    bus1.req      = 2'b01;
    ok = 0;
    for (int c = 0; c < FRAME1; c++) begin
      @(negedge clk);
      if (bus1.gnt != '0) begin ok = 1; break; end
    end
    bus1.req = '0;
    check("mid_gnt_seen", 32'(ok), 1);
    ok = 0;
    for (int c = 0; c < FRAME1; c++) begin
      @(negedge clk);
      if (num1 == 4'd5) begin ok = 1; break; end
    end
    check("mid_reach_num5", 32'(ok), 1);
    #2 do_reset();
    g0 = g1_cnt; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus1.gnt != '0 || sel1 || busy1) bad++;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_no_gnt", g1_cnt - g0, 0);
  endtask

  task automatic pulse_during_send();
    int g0;
    bit ok;
    g0 = g1_cnt;
    exp_q.push_back({2'(rr_pick(model_rr, 2'b01)), 8'h5A});
    model_rr = 0;
    @(negedge clk);
    bus1.req_data = {8'h00, 8'h5A};
    bus1.req      = 2'b01;
    ok = 0;
    for (int c = 0; c < FRAME1; c++) begin
      @(negedge clk);
      if (bus1.gnt != '0) begin ok = 1; break; end
    end
    bus1.req = '0;
    check("pulse_first_gnt", 32'(ok), 1);
    repeat (8) @(negedge clk);
    bus1.req = 2'b01;
    repeat (5) @(negedge clk);
    bus1.req = '0;
    wait_idle();
    repeat (FRAME1 + 10) @(negedge clk);
    check("pulse_gnt_count", g1_cnt - g0, 1);
    check("pulse_q_empty", exp_q.size(), 0);
  endtask

  task automatic single_req_stream();
    int got, cyc, k, hi, nerr;
    got = 0; cyc = 0; k = 0; hi = 0; nerr = 0;
    @(negedge clk);
    bus2.req_data = 8'hFF;
    bus2.req      = 1'b1;
    for (int c = 0; c < 8 * (FRAME2 + 1); c++) begin
      @(negedge clk);
      cyc++;
      if (bus2.gnt != '0) begin
        if (got == 0) begin
          check("b2_first_latency", cyc, 1);
        end else begin
          check("b2_period", cyc, FRAME2 + 1);
          check("b2_high_cycles", hi, FRAME2);
        end
        check("b2_tx_d", 32'(d2), 32'hFF);
        got++; cyc = 0; k = 0; hi = 0;
      end
      if (sel2) begin
        if (num2 !== 4'(k / B2)) nerr++;
        hi++;
      end
      k++;
      if (got == 5) break;
    end
    bus2.req = 1'b0;
    check("b2_grants", got, 5);
    check("b2_idx_err", nerr, 0);
  endtask

  initial begin
    bus1.req = '0; bus1.req_data = '0;
    bus2.req = '0; bus2.req_data = '0;
    #1;
    check_reset_vals("init");
    check("b2_rst_busy", 32'(busy2), 0);
    check("b2_rst_state", 32'(st2), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);

    run_burst(2'b11, 8'h11, 8'h22, 4);
    run_burst(2'b01, 8'hA5, 8'h00, 1);
    do_reset();
    run_burst(2'b10, 8'h00, 8'h33, 1);
    run_burst(2'b11, 8'h44, 8'h55, 1);
    midframe_reset();
    pulse_during_send();
    for (int r = 0; r < 8; r++) begin
      run_burst(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $urandom_range(1, 3));
    end
    single_req_stream();
    repeat (FRAME1 + 5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
